// File: rtl/rt_jtag_pkg.sv
// Shared TAP definitions: state encoding, instruction codes, DMI status and DTMCS layout.
// Latency: none (types, constants and one pure function).
// Backpressure: not applicable.
package rt_jtag_pkg;

    typedef enum logic [3:0] {
        TAP_TLR,
        TAP_RTI,
        TAP_SEL_DR,
        TAP_CAP_DR,
        TAP_SHIFT_DR,
        TAP_EXIT1_DR,
        TAP_PAUSE_DR,
        TAP_EXIT2_DR,
        TAP_UPD_DR,
        TAP_SEL_IR,
        TAP_CAP_IR,
        TAP_SHIFT_IR,
        TAP_EXIT1_IR,
        TAP_PAUSE_IR,
        TAP_EXIT2_IR,
        TAP_UPD_IR
    } tap_state_t;

    localparam int unsigned IR_W = 5;

    localparam logic [IR_W-1:0] IR_IDCODE  = 5'h01;
    localparam logic [IR_W-1:0] IR_DTMCS   = 5'h10;
    localparam logic [IR_W-1:0] IR_DMI     = 5'h11;
    localparam logic [IR_W-1:0] IR_BYPASS  = 5'h1F;
    localparam logic [IR_W-1:0] IR_CAPTURE = 5'b00001;

    localparam logic [1:0] DMISTAT_OK     = 2'd0;
    localparam logic [1:0] DMISTAT_FAILED = 2'd2;
    localparam logic [1:0] DMISTAT_BUSY   = 2'd3;

    localparam logic [1:0] DMI_OP_NOP   = 2'd0;
    localparam logic [1:0] DMI_OP_READ  = 2'd1;
    localparam logic [1:0] DMI_OP_WRITE = 2'd2;

    localparam int unsigned DTMCS_VERSION_LSB   = 0;
    localparam int unsigned DTMCS_ABITS_LSB     = 4;
    localparam int unsigned DTMCS_DMISTAT_LSB   = 10;
    localparam int unsigned DTMCS_IDLE_LSB      = 12;
    localparam int unsigned DTMCS_DMIRESET_BIT  = 16;
    localparam int unsigned DTMCS_HARDRESET_BIT = 17;

    localparam logic [3:0] DTMCS_VERSION = 4'd1;
    localparam logic [2:0] DTMCS_IDLE    = 3'd1;

    // TDO follows the IR shift register only while the FSM is in the IR column.
    function automatic logic is_ir_state(input tap_state_t s);
        return s inside {TAP_CAP_IR, TAP_SHIFT_IR, TAP_EXIT1_IR,
                         TAP_PAUSE_IR, TAP_EXIT2_IR, TAP_UPD_IR};
    endfunction

    // Read-only view of DTMCS; the two reset request bits always read back as 0.
    function automatic logic [31:0] dtmcs_word(input logic [1:0] dmistat,
                                               input logic [5:0] abits);
        logic [31:0] w;
        w = '0;
        w[DTMCS_VERSION_LSB +: 4] = DTMCS_VERSION;
        w[DTMCS_ABITS_LSB   +: 6] = abits;
        w[DTMCS_DMISTAT_LSB +: 2] = dmistat;
        w[DTMCS_IDLE_LSB    +: 3] = DTMCS_IDLE;
        return w;
    endfunction

endpackage

// File: rtl/rt_jtag_tap_fsm.sv
// IEEE 1149.1 16-state TAP controller stepped by a one-cycle tck-rise enable.
// Latency: state updates in the cycle after the enable; trst_n low forces TLR next cycle.
// Backpressure: none; every enable advances the FSM.
module rt_jtag_tap_fsm
    import rt_jtag_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tck_rise,
    input  logic       tms,
    input  logic       trst_n,
    output tap_state_t state
);

    tap_state_t state_q, state_d;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= TAP_TLR;
        else         state_q <= state_d;
    end

    // Standard TMS transitions; test reset overrides any pending step.
    always_comb begin
        state_d = state_q;
        if (!trst_n) begin
            state_d = TAP_TLR;
        end else if (tck_rise) begin
            unique case (state_q)
                TAP_TLR:      state_d = tms ? TAP_TLR      : TAP_RTI;
                TAP_RTI:      state_d = tms ? TAP_SEL_DR   : TAP_RTI;
                TAP_SEL_DR:   state_d = tms ? TAP_SEL_IR   : TAP_CAP_DR;
                TAP_CAP_DR:   state_d = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
                TAP_SHIFT_DR: state_d = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
                TAP_EXIT1_DR: state_d = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
                TAP_PAUSE_DR: state_d = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
                TAP_EXIT2_DR: state_d = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
                TAP_UPD_DR:   state_d = tms ? TAP_SEL_DR   : TAP_RTI;
                TAP_SEL_IR:   state_d = tms ? TAP_TLR      : TAP_CAP_IR;
                TAP_CAP_IR:   state_d = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
                TAP_SHIFT_IR: state_d = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
                TAP_EXIT1_IR: state_d = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
                TAP_PAUSE_IR: state_d = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
                TAP_EXIT2_IR: state_d = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
                TAP_UPD_IR:   state_d = tms ? TAP_SEL_DR   : TAP_RTI;
                default:      state_d = TAP_TLR;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: rtl/rt_jtag_tap.sv
// JTAG TAP with IDCODE/DTMCS/DMI/BYPASS registers, oversampling the JTAG pins in clk_i.
// Latency: pins seen after a 2-flop sync; DR/IR act on the following cycle, DMI request 1 cycle after Update-DR.
// Backpressure: dmi_req_valid_o held with stable payload until dmi_req_ready_i; responses always accepted.
module rt_jtag_tap
    import rt_jtag_pkg::*;
#(
    parameter logic [31:0] IdcodeValue = 32'h0000_0DB3,
    parameter int unsigned DmiAbits    = 7
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                jtag_tck_i,
    input  logic                jtag_tms_i,
    input  logic                jtag_trst_ni,
    input  logic                jtag_td_i,
    output logic                jtag_td_o,
    output logic                dmi_req_valid_o,
    input  logic                dmi_req_ready_i,
    output logic [DmiAbits-1:0] dmi_req_addr_o,
    output logic [31:0]         dmi_req_data_o,
    output logic [1:0]          dmi_req_op_o,
    input  logic                dmi_resp_valid_i,
    input  logic [31:0]         dmi_resp_data_i,
    input  logic                dmi_resp_err_i
);

    localparam int unsigned DrW = DmiAbits + 34;

    logic [1:0] tck_sync, tms_sync, tdi_sync, trst_sync;
    logic       tck_q;
    logic       tck_s, tms_s, tdi_s, trst_s;
    logic       tck_rise, tck_fall, tap_rise;
    tap_state_t state;

    logic [IR_W-1:0]     ir_q, ir_shift_q;
    logic [DrW-1:0]      dr_q, dr_capture, dr_shifted;
    logic                req_valid_q, resp_pending_q;
    logic [DmiAbits-1:0] req_addr_q;
    logic [31:0]         req_data_q, resp_data_q;
    logic [1:0]          req_op_q, dmistat_q;
    logic                td_q;
    logic                update_dmi, update_dtmcs, busy;
    logic [1:0]          upd_op;

    // Two-flop synchronizers plus a registered copy of tck for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tck_sync  <= '0;
            tms_sync  <= '0;
            tdi_sync  <= '0;
            trst_sync <= '0;
            tck_q     <= 1'b0;
        end else begin
            tck_sync  <= {tck_sync[0],  jtag_tck_i};
            tms_sync  <= {tms_sync[0],  jtag_tms_i};
            tdi_sync  <= {tdi_sync[0],  jtag_td_i};
            trst_sync <= {trst_sync[0], jtag_trst_ni};
            tck_q     <= tck_sync[1];
        end
    end

    assign tck_s    = tck_sync[1];
    assign tms_s    = tms_sync[1];
    assign tdi_s    = tdi_sync[1];
    assign trst_s   = trst_sync[1];
    assign tck_rise = tck_s & ~tck_q;
    assign tck_fall = ~tck_s & tck_q;
    assign tap_rise = tck_rise & trst_s;

    rt_jtag_tap_fsm u_fsm (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .tck_rise (tck_rise),
        .tms      (tms_s),
        .trst_n   (trst_s),
        .state    (state)
    );

    // Capture value and one-step shift of the DR selected by the current instruction.
    always_comb begin
        dr_capture = '0;
        dr_shifted = '0;
        unique case (ir_q)
            IR_IDCODE: begin
                dr_capture[31:0] = IdcodeValue;
                dr_shifted[31:0] = {tdi_s, dr_q[31:1]};
            end
            IR_DTMCS: begin
                dr_capture[31:0] = dtmcs_word(dmistat_q, 6'(DmiAbits));
                dr_shifted[31:0] = {tdi_s, dr_q[31:1]};
            end
            IR_DMI: begin
                dr_capture = {req_addr_q, resp_data_q, dmistat_q};
                dr_shifted = {tdi_s, dr_q[DrW-1:1]};
            end
            default: begin
                dr_shifted[0] = tdi_s;
            end
        endcase
    end

    // IR and DR capture/shift/update on tck rise; test reset reloads IDCODE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ir_q       <= IR_IDCODE;
            ir_shift_q <= '0;
            dr_q       <= '0;
        end else begin
            if (!trst_s || state == TAP_TLR) ir_q <= IR_IDCODE;
            else if (tap_rise && state == TAP_UPD_IR) ir_q <= ir_shift_q;
            if (tap_rise) begin
                unique case (state)
                    TAP_CAP_IR:   ir_shift_q <= IR_CAPTURE;
                    TAP_SHIFT_IR: ir_shift_q <= {tdi_s, ir_shift_q[IR_W-1:1]};
                    TAP_CAP_DR:   dr_q       <= dr_capture;
                    TAP_SHIFT_DR: dr_q       <= dr_shifted;
                    default: ;
                endcase
            end
        end
    end

    // TDO changes only on tck fall, from the shift register of the active column.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)       td_q <= 1'b0;
        else if (tck_fall) td_q <= is_ir_state(state) ? ir_shift_q[0] : dr_q[0];
    end

    assign update_dmi   = tap_rise && state == TAP_UPD_DR && ir_q == IR_DMI;
    assign update_dtmcs = tap_rise && state == TAP_UPD_DR && ir_q == IR_DTMCS;
    assign upd_op       = dr_q[1:0];
    assign busy         = req_valid_q | resp_pending_q;

    // DMI request issue/handshake, response capture and sticky status; later writes take priority.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_valid_q    <= 1'b0;
            resp_pending_q <= 1'b0;
            req_addr_q     <= '0;
            req_data_q     <= '0;
            req_op_q       <= DMI_OP_NOP;
            resp_data_q    <= '0;
            dmistat_q      <= DMISTAT_OK;
        end else begin
            if (req_valid_q && dmi_req_ready_i) begin
                req_valid_q    <= 1'b0;
                resp_pending_q <= 1'b1;
            end
            if (dmi_resp_valid_i) begin
                resp_data_q    <= dmi_resp_data_i;
                resp_pending_q <= 1'b0;
                if (dmi_resp_err_i && dmistat_q == DMISTAT_OK) dmistat_q <= DMISTAT_FAILED;
            end
            if (update_dmi && (upd_op == DMI_OP_READ || upd_op == DMI_OP_WRITE)) begin
                if (busy) begin
                    dmistat_q <= DMISTAT_BUSY;
                end else if (dmistat_q == DMISTAT_OK) begin
                    req_addr_q  <= dr_q[DrW-1:34];
                    req_data_q  <= dr_q[33:2];
                    req_op_q    <= upd_op;
                    req_valid_q <= 1'b1;
                end
            end
            if (update_dtmcs) begin
                if (dr_q[DTMCS_DMIRESET_BIT] || dr_q[DTMCS_HARDRESET_BIT]) dmistat_q <= DMISTAT_OK;
                if (dr_q[DTMCS_HARDRESET_BIT]) begin
                    req_valid_q    <= 1'b0;
                    resp_pending_q <= 1'b0;
                end
            end
        end
    end

    assign jtag_td_o       = td_q;
    assign dmi_req_valid_o = req_valid_q;
    assign dmi_req_addr_o  = req_addr_q;
    assign dmi_req_data_o  = req_data_q;
    assign dmi_req_op_o    = req_op_q;

endmodule

// File: tb/tb_rt_jtag_tap.sv
// Bench for rt_jtag_tap: directed JTAG scans with queued expectations, checked by monitors.
// Latency: each tck phase lasts 4 clk cycles.
// Backpressure: DMI ready is given after the request has been valid for 5 cycles.
`timescale 1ns/1ps
module tb_rt_jtag_tap;
    import rt_jtag_pkg::*;

    typedef struct {
        logic [63:0] exp;
        int          len;
        string       name;
    } scan_t;

    typedef struct {
        logic [6:0]  addr;
        logic [31:0] data;
        logic [1:0]  op;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        jtag_tck = 1'b0;
    logic        jtag_tms = 1'b1;
    logic        jtag_trst_n = 1'b1;
    logic        jtag_tdi = 1'b0;
    logic        jtag_td_o;
    logic        dmi_req_valid;
    logic        dmi_req_ready = 1'b0;
    logic [6:0]  dmi_req_addr;
    logic [31:0] dmi_req_data;
    logic [1:0]  dmi_req_op;
    logic        dmi_resp_valid = 1'b0;
    logic [31:0] dmi_resp_data = '0;
    logic        dmi_resp_err = 1'b0;

    int    checks = 0;
    int    failures = 0;
    int    req_seen = 0;
    int    wait_cnt = 0;
    logic  shifting = 1'b0;
    scan_t scan_q[$];
    req_t  exp_req_q[$];

    rt_jtag_tap #(.IdcodeValue(32'h0000_0DB3), .DmiAbits(7)) u_dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .jtag_tck_i       (jtag_tck),
        .jtag_tms_i       (jtag_tms),
        .jtag_trst_ni     (jtag_trst_n),
        .jtag_td_i        (jtag_tdi),
        .jtag_td_o        (jtag_td_o),
        .dmi_req_valid_o  (dmi_req_valid),
        .dmi_req_ready_i  (dmi_req_ready),
        .dmi_req_addr_o   (dmi_req_addr),
        .dmi_req_data_o   (dmi_req_data),
        .dmi_req_op_o     (dmi_req_op),
        .dmi_resp_valid_i (dmi_resp_valid),
        .dmi_resp_data_i  (dmi_resp_data),
        .dmi_resp_err_i   (dmi_resp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One full tck period; TMS/TDI change with the falling edge.
    task automatic jtag(input logic tms, input logic tdi);
        jtag_tms = tms;
        jtag_tdi = tdi;
        repeat (4) @(negedge clk);
        jtag_tck = 1'b1;
        repeat (4) @(negedge clk);
        jtag_tck = 1'b0;
    endtask

    // From Run-Test/Idle through a DR scan and back to Run-Test/Idle.
    task automatic scan_dr(input logic [63:0] din, input int len,
                           input logic [63:0] exp, input string name);
        scan_t s;
        s.exp = exp; s.len = len; s.name = name;
        scan_q.push_back(s);
        jtag(1'b1, 1'b0);
        jtag(1'b0, 1'b0);
        jtag(1'b0, 1'b0);
        shifting = 1'b1;
        for (int i = 0; i < len; i++) jtag(i == len - 1, din[i]);
        shifting = 1'b0;
        jtag(1'b1, 1'b0);
        jtag(1'b0, 1'b0);
    endtask

    // IR scan from Run-Test/Idle; the captured IR must always read 5'b00001.
    task automatic scan_ir(input logic [4:0] ir, input string name);
        scan_t s;
        s.exp = 64'(IR_CAPTURE); s.len = 5; s.name = name;
        scan_q.push_back(s);
        jtag(1'b1, 1'b0);
        jtag(1'b1, 1'b0);
        jtag(1'b0, 1'b0);
        jtag(1'b0, 1'b0);
        shifting = 1'b1;
        for (int i = 0; i < 5; i++) jtag(i == 4, ir[i]);
        shifting = 1'b0;
        jtag(1'b1, 1'b0);
        jtag(1'b0, 1'b0);
    endtask

    task automatic expect_req(input logic [6:0] addr, input logic [31:0] data, input logic [1:0] op);
        req_t r;
        r.addr = addr; r.data = data; r.op = op;
        exp_req_q.push_back(r);
    endtask

    task automatic wait_req(input int target, input string name);
        for (int t = 0; t < 200 && req_seen < target; t++) @(negedge clk);
        check(name, 64'(req_seen), 64'(target));
    endtask

    task automatic give_resp(input logic [31:0] data, input logic err);
        dmi_resp_valid = 1'b1;
        dmi_resp_data  = data;
        dmi_resp_err   = err;
        @(negedge clk);
        dmi_resp_valid = 1'b0;
        dmi_resp_err   = 1'b0;
    endtask

    // TDO monitor: collects one bit per tck rise during a shift, compares against the queue head.
    initial begin : scan_mon
        logic [63:0] obs;
        int          n;
        scan_t       s;
        forever begin
            wait (shifting);
            obs = '0;
            n = 0;
            while (shifting) begin
                @(posedge jtag_tck or negedge shifting);
                if (shifting && n < 64) begin
                    obs[n] = jtag_td_o;
                    n++;
                end
            end
            if (scan_q.size() == 0) begin
                check("scan_unexpected", 64'(n), 64'(0));
            end else begin
                s = scan_q.pop_front();
                check({s.name, "_len"}, 64'(n), 64'(s.len));
                check(s.name, obs, s.exp);
            end
        end
    end

    // DMI monitor: grants ready after 5 valid cycles, checks the payload and the valid drop.
    initial begin : req_mon
        req_t r;
        forever begin
            @(negedge clk);
            if (dmi_req_ready) begin
                dmi_req_ready = 1'b0;
                check("req_valid_drop", 64'(dmi_req_valid), 64'(0));
            end else if (dmi_req_valid) begin
                wait_cnt++;
                if (wait_cnt == 5) begin
                    wait_cnt = 0;
                    if (exp_req_q.size() == 0) begin
                        check("req_unexpected", 64'(dmi_req_valid), 64'(0));
                    end else begin
                        r = exp_req_q.pop_front();
                        check("req_addr", 64'(dmi_req_addr), 64'(r.addr));
                        check("req_data", 64'(dmi_req_data), 64'(r.data));
                        check("req_op",   64'(dmi_req_op),   64'(r.op));
                    end
                    dmi_req_ready = 1'b1;
                    req_seen++;
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        repeat (3) @(negedge clk);
        check("rst_tdo",   64'(jtag_td_o),     64'(0));
        check("rst_valid", 64'(dmi_req_valid), 64'(0));
        check("rst_addr",  64'(dmi_req_addr),  64'(0));
        check("rst_data",  64'(dmi_req_data),  64'(0));
        check("rst_op",    64'(dmi_req_op),    64'(0));
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_state", 64'(u_dut.u_fsm.state), 64'(TAP_TLR));

        repeat (5) jtag(1'b1, 1'b0);
        jtag(1'b0, 1'b0);
        check("rti_state", 64'(u_dut.u_fsm.state), 64'(TAP_RTI));
        scan_dr(64'h0, 32, 64'h0000_0DB3, "idcode");

        scan_ir(5'h1F, "ir_bypass");
        scan_dr(64'h0A5, 9, 64'h14A, "bypass");

        scan_ir(5'h10, "ir_dtmcs");
        scan_dr(64'h0, 32, 64'h0000_1071, "dtmcs_idle");

        scan_ir(5'h11, "ir_dmi");
        expect_req(7'h10, 32'h1, 2'd2);
        scan_dr({7'h10, 32'h1, 2'd2}, 41, 64'h0, "dmi_cap_reset");
        wait_req(1, "req_write_seen");
        scan_dr({7'h10, 32'h1, 2'd2}, 41, {7'h10, 32'h0, 2'd0}, "dmi_cap_after_write");
        scan_dr(64'h0, 41, {7'h10, 32'h0, 2'd3}, "dmi_cap_busy");
        give_resp(32'h0, 1'b0);

        scan_ir(5'h10, "ir_dtmcs2");
        scan_dr(64'h1_0000, 32, 64'h0000_1C71, "dtmcs_busy");
        scan_dr(64'h0, 32, 64'h0000_1071, "dtmcs_cleared");

        scan_ir(5'h11, "ir_dmi2");
        expect_req(7'h05, 32'h0, 2'd1);
        scan_dr({7'h05, 32'h0, 2'd1}, 41, {7'h10, 32'h0, 2'd0}, "dmi_cap_pre_read");
        wait_req(2, "req_read_seen");
        give_resp(32'hDEAD_BEEF, 1'b1);
        scan_dr(64'h0, 41, {7'h05, 32'hDEAD_BEEF, 2'd2}, "dmi_cap_read_err");

        jtag(1'b1, 1'b0);
        jtag(1'b0, 1'b0);
        jtag(1'b0, 1'b0);
        jtag(1'b0, 1'b1);
        jtag(1'b0, 1'b1);
        check("pre_trst_state", 64'(u_dut.u_fsm.state), 64'(TAP_SHIFT_DR));
        jtag_trst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("trst_state", 64'(u_dut.u_fsm.state), 64'(TAP_TLR));
        check("trst_ir",    64'(u_dut.ir_q),        64'(IR_IDCODE));
        jtag_trst_n = 1'b1;
        repeat (4) @(negedge clk);
        jtag(1'b0, 1'b0);
        scan_dr(64'h0, 32, 64'h0000_0DB3, "idcode_after_trst");

        repeat (20) @(negedge clk);
        check("req_total",     64'(req_seen),          64'(2));
        check("req_q_left",    64'(exp_req_q.size()),  64'(0));
        check("scan_q_left",   64'(scan_q.size()),     64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rt_jtag_tap.md
RT_JTAG_TAP -- requirements
Module: rt_jtag_tap

Interface
REQ-001 Parameter IdcodeValue, 32'h0000_0DB3, value returned by the IDCODE DR; bit 0 SHALL be 1.
REQ-002 Parameter DmiAbits, 7, DMI address width; DMI DR width is DmiAbits+34.
REQ-003 clk_i  in  1  system clock; the only clock; all flops on its rising edge.
REQ-004 rst_ni  in  1  asynchronous active-low reset.
REQ-005 jtag_tck_i, jtag_tms_i, jtag_trst_ni, jtag_td_i  in  1 each  asynchronous JTAG pins; oversampled in the clk_i domain.
REQ-006 jtag_td_o  out  1  TDO.
REQ-007 dmi_req_valid_o / dmi_req_ready_i  out/in  1  DMI request handshake.
REQ-008 dmi_req_addr_o  out  DmiAbits; dmi_req_data_o  out  32; dmi_req_op_o  out  2 (1=read, 2=write).
REQ-009 dmi_resp_valid_i  in  1; dmi_resp_data_i  in  32; dmi_resp_err_i  in  1.

Function
REQ-010 tck, tms, tdi and trst_n SHALL each pass a 2-flop synchronizer; tck edges detected against a registered copy of the synchronized tck.
REQ-011 Operation is specified for tck high and low phases of at least 3 clk_i cycles each.
REQ-012 On a detected tck rise the block SHALL sample TMS/TDI, advance the TAP FSM and shift the selected register, all in the same clk_i cycle.
REQ-013 On a detected tck fall jtag_td_o SHALL update to the LSB of the active shift register (DR or IR per state); it holds its value otherwise.
REQ-014 TAP FSM: all 16 IEEE 1149.1 states with standard TMS transitions; five TMS=1 rises from any state reach Test-Logic-Reset.
REQ-015 IR is 5 bits; Capture-IR loads 5'b00001; Update-IR commits; Test-Logic-Reset loads IDCODE (5'h01).
REQ-016 Instructions: 5'h01 IDCODE (32b), 5'h10 DTMCS (32b), 5'h11 DMI (DmiAbits+34), 5'h1F and all others BYPASS (1b, captures 0).
REQ-017 Capture-DR: IDCODE←IdcodeValue; DTMCS←{14'b0, 2'b00, 1'b0, 3'd1 idle, dmistat[1:0], abits[5:0]=DmiAbits, version 4'd1}; DMI←{last addr, last response data, dmistat}.
REQ-018 Shift-DR/IR: shift right, TDI into MSB.
REQ-019 Update-DR of DTMCS: bit16=1 clears sticky dmistat; bit17=1 also clears dmistat and drops any pending request (valid low next cycle).
REQ-020 Update-DR of DMI with op 1/2, dmistat=0 and no request outstanding: latch addr/data/op, assert dmi_req_valid_o the next clk_i cycle, hold stable until dmi_req_ready_i sampled high.
REQ-021 Update-DR of DMI while a request or response is outstanding: no new request, dmistat←3 (sticky); op 0 SHALL be a no-op.
REQ-022 dmi_resp_valid_i is always accepted; data stored; dmi_resp_err_i=1 sets dmistat←2 unless already nonzero.
REQ-023 Synchronized trst_n low SHALL force Test-Logic-Reset, IR←IDCODE, within 3 clk_i cycles of the pin falling, including mid-shift; DMI request/dmistat unaffected.

Reset
REQ-024 rst_ni low: FSM Test-Logic-Reset, IR=5'h01, all shift registers 0, jtag_td_o=0, dmi_req_valid_o=0, addr/data/op outputs 0, dmistat=0, stored response 0, synchronizers 0 (tck registered low).
REQ-025 Release of rst_ni SHALL NOT generate a tck edge.

Structure
REQ-026 Shared package rt_jtag_pkg SHALL hold the TAP state enum, instruction codes, dmistat encodings and DTMCS field positions.
REQ-027 One sub-module, rt_jtag_tap_fsm (16-state FSM, tck-rise enable input), SHALL be instantiated; datapath stays in rt_jtag_tap.

Verification
REQ-028 Reset, TMS=1 x5, shift 32 DR bits -> TDO stream equals 32'h0000_0DB3 LSB first.
REQ-029 IR=5'h1F, shift 8'hA5 through DR -> TDO returns 8'hA5 delayed by one tck.
REQ-030 DMI write addr=7'h10 data=32'h1 op=2 -> one request with those values, held until ready given after 5 cycles; next DMI capture dmistat=0.
REQ-031 Second DMI Update-DR before dmi_resp_valid_i -> no second request, capture shows dmistat=3; DTMCS write bit16=1 -> dmistat=0.
REQ-032 DMI read with dmi_resp_err_i=1, data 32'hDEAD_BEEF -> next capture returns that data with dmistat=2.
REQ-033 trst_n pulsed low mid Shift-DR -> FSM Test-Logic-Reset within 3 cycles, subsequent IDCODE read correct.
